// File: rtl/anim_frame_sequencer.sv
// Sprite animation sequencer: steps a frame index every HOLD_FRAMES
// frame_clk edges in loop, ping-pong or one-shot mode.
module anim_frame_sequencer #(
  parameter int NUM_FRAMES  = 4,
  parameter int HOLD_FRAMES = 10,
  parameter int IDX_W  = ($clog2(NUM_FRAMES) > 0 ? $clog2(NUM_FRAMES) : 1),
  parameter int HOLD_W = ($clog2(HOLD_FRAMES) > 0 ? $clog2(HOLD_FRAMES) : 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic             enable,
  input  logic             restart,
  input  logic [1:0]       mode,
  output logic [IDX_W-1:0] frame_idx,
  output logic             frame_tick,
  output logic             seq_done,
  output logic             busy
);

  typedef enum logic {S_RUN, S_DONE} state_t;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  logic              fc_d1_q, fc_d2_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              dir_q, dir_d;
  state_t            state_q, state_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              qedge, adv;

  assign qedge = fc_d1_q & ~fc_d2_q & enable;

  always_comb begin
    hold_d  = hold_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    state_d = state_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    // direction only has meaning in ping-pong
    if (mode != 2'b01) dir_d = 1'b0;
    if (restart) begin
      hold_d  = '0;
      idx_d   = '0;
      dir_d   = 1'b0;
      state_d = S_RUN;
    end else if (qedge && state_q == S_RUN) begin
      if (hold_q == HOLD_LAST) begin
        hold_d = '0;
        adv    = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
    if (adv) begin
      unique case (1'b1)
        (mode == 2'b01): begin
          if (NUM_FRAMES == 1) begin
            done_d = 1'b1;
          end else if (!dir_q) begin
            if (idx_q < IDX_LAST) begin
              idx_d = idx_q + 1'b1;
            end else begin
              idx_d = idx_q - 1'b1;
              dir_d = 1'b1;
            end
          end else if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
            if (idx_q == IDX_ONE) begin
              dir_d  = 1'b0;
              done_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            dir_d = 1'b0;
          end
        end
        (mode == 2'b10): begin
          if (idx_q < IDX_LAST) begin
            idx_d = idx_q + 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: begin
          if (idx_q < IDX_LAST) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d  = '0;
            done_d = 1'b1;
          end
        end
      endcase
    end
    tick_d = (idx_d != idx_q) && !restart;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fc_d1_q <= 1'b0;
      fc_d2_q <= 1'b0;
      hold_q  <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      state_q <= S_RUN;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      fc_d1_q <= frame_clk;
      fc_d2_q <= fc_d1_q;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= (state_d == S_RUN);
    end
  end

  assign frame_idx  = idx_q;
  assign frame_tick = tick_q;
  assign seq_done   = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed bench for anim_frame_sequencer with NUM_FRAMES=4,
// HOLD_FRAMES=3 and hand-computed frame index sequences.
module tb_anim_frame_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic       enable;
  logic       restart;
  logic [1:0] mode;
  logic [1:0] frame_idx;
  logic       frame_tick;
  logic       seq_done;
  logic       busy;

  always #5 Clk = ~Clk;

  anim_frame_sequencer #(
    .NUM_FRAMES(4),
    .HOLD_FRAMES(3)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk(frame_clk),
    .enable(enable),
    .restart(restart),
    .mode(mode),
    .frame_idx(frame_idx),
    .frame_tick(frame_tick),
    .seq_done(seq_done),
    .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int ticks = 0;
  int dones = 0;
  int edge_n = 0;
  int done_at = -1;
  int done_idx = -1;
  int t0, d0;

  always @(negedge Clk) begin
    if (frame_tick) ticks++;
    if (seq_done) begin
      dones++;
      done_at = edge_n;
      done_idx = int'(frame_idx);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse();
    @(negedge Clk);
    edge_n++;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    restart = 1'b0;
    frame_clk = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    edge_n = 0;
    @(negedge Clk);
  endtask

  int pp_exp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  initial begin
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    enable = 1'b1;
    restart = 1'b0;
    mode = 2'b00;
    apply_reset();
    chk("rst_idx", frame_idx, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_busy", busy, 1);

    // loop
    t0 = ticks; d0 = dones;
    for (int e = 1; e <= 12; e++) begin
      pulse();
      chk($sformatf("loop_idx_e%0d", e), frame_idx, (e / 3) % 4);
    end
    chk("loop_ticks", ticks - t0, 4);
    chk("loop_dones", dones - d0, 1);
    chk("loop_done_at", done_at, 12);
    chk("loop_done_idx", done_idx, 0);

    // ping-pong
    mode = 2'b01;
    apply_reset();
    t0 = ticks; d0 = dones;
    for (int e = 1; e <= 21; e++) begin
      pulse();
      if (e % 3 == 0)
        chk($sformatf("pp_idx_e%0d", e), frame_idx, pp_exp[e / 3]);
      if (e == 17) chk("pp_no_done_yet", dones - d0, 0);
    end
    chk("pp_ticks", ticks - t0, 7);
    chk("pp_dones", dones - d0, 1);
    chk("pp_done_at", done_at, 18);

    // one-shot
    mode = 2'b10;
    apply_reset();
    t0 = ticks; d0 = dones;
    for (int e = 1; e <= 15; e++) begin
      pulse();
      if (e % 3 == 0)
        chk($sformatf("os_idx_e%0d", e), frame_idx, (e / 3 > 3) ? 3 : e / 3);
      if (e == 12) chk("os_busy_e12", busy, 0);
    end
    chk("os_busy_end", busy, 0);
    chk("os_ticks", ticks - t0, 3);
    chk("os_dones", dones - d0, 1);
    chk("os_done_at", done_at, 12);
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    chk("os_rs_idx", frame_idx, 0);
    chk("os_rs_busy", busy, 1);
    repeat (2) @(negedge Clk);
    chk("os_rs_dones", dones - d0, 1);

    // pause
    mode = 2'b00;
    apply_reset();
    pulse();
    enable = 1'b0;
    repeat (5) pulse();
    chk("pause_idx", frame_idx, 0);
    enable = 1'b1;
    pulse();
    chk("pause_idx_p1", frame_idx, 0);
    pulse();
    chk("pause_idx_p2", frame_idx, 1);

    // held-high frame_clk counts once
    apply_reset();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (100) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    chk("hold_idx0", frame_idx, 0);
    pulse();
    chk("hold_idx1", frame_idx, 0);
    pulse();
    chk("hold_idx2", frame_idx, 1);

    // restart coincident with the 3rd qualified edge
    apply_reset();
    pulse();
    pulse();
    t0 = ticks;
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rsedge_idx", frame_idx, 0);
    chk("rsedge_ticks", ticks - t0, 0);
    pulse();
    pulse();
    chk("rsedge_hold", frame_idx, 0);
    pulse();
    chk("rsedge_adv", frame_idx, 1);

    // reset mid ping-pong, dir down at idx 2
    mode = 2'b01;
    apply_reset();
    repeat (12) pulse();
    chk("mid_pre_idx", frame_idx, 2);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("mid_idx", frame_idx, 0);
    chk("mid_tick", frame_tick, 0);
    chk("mid_done", seq_done, 0);
    chk("mid_busy", busy, 1);
    repeat (3) pulse();
    chk("mid_adv", frame_idx, 1);
    repeat (3) pulse();
    chk("mid_adv2", frame_idx, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
